// File: rtl/wb_pipe_if.sv
// Bus bundle for wb_pipe: the EX result triple and pipeline controls going in,
// the two stage contents and the retired-write count coming out.
interface wb_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              ex_wreg_i;
    logic [ADDR_W-1:0] ex_waddr_i;
    logic [DATA_W-1:0] ex_wdata_i;
    logic [1:0]        stall_i;
    logic              flush_i;

    logic              mem_wreg_o;
    logic [ADDR_W-1:0] mem_waddr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              wb_wreg_o;
    logic [ADDR_W-1:0] wb_waddr_o;
    logic [DATA_W-1:0] wb_wdata_o;
    logic [CNT_W-1:0]  wb_count_o;

    modport master (
        output ex_wreg_i, ex_waddr_i, ex_wdata_i, stall_i, flush_i,
        input  mem_wreg_o, mem_waddr_o, mem_wdata_o,
        input  wb_wreg_o, wb_waddr_o, wb_wdata_o, wb_count_o
    );

    modport slave (
        input  ex_wreg_i, ex_waddr_i, ex_wdata_i, stall_i, flush_i,
        output mem_wreg_o, mem_waddr_o, mem_wdata_o,
        output wb_wreg_o, wb_waddr_o, wb_wdata_o, wb_count_o
    );
endinterface

// File: rtl/wb_pipe.sv
// EX/MEM and MEM/WB result registers with stall/flush handling, bypass export
// of both stages, and a free-running count of retired register writes.
module wb_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic     clk,
    input  logic     rst,
    wb_pipe_if.slave bus
);

    logic              mem_wreg_q,  mem_wreg_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              wb_wreg_q,   wb_wreg_d;
    logic [ADDR_W-1:0] wb_waddr_q,  wb_waddr_d;
    logic [DATA_W-1:0] wb_wdata_q,  wb_wdata_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;

    logic hold_mem;
    logic hold_wb;
    logic ex_kill;

    always_comb begin
        // A held MEM/WB stage forces EX/MEM to hold as well.
        hold_wb  = bus.stall_i[1];
        hold_mem = bus.stall_i[1] | bus.stall_i[0];
        ex_kill  = bus.ex_wreg_i && (bus.ex_waddr_i == '0);

        mem_wreg_d  = mem_wreg_q;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        wb_wreg_d   = wb_wreg_q;
        wb_waddr_d  = wb_waddr_q;
        wb_wdata_d  = wb_wdata_q;
        cnt_d       = cnt_q + CNT_W'(wb_wreg_q);

        if (bus.flush_i) begin
            mem_wreg_d  = 1'b0;
            mem_waddr_d = '0;
            mem_wdata_d = '0;
            wb_wreg_d   = 1'b0;
            wb_waddr_d  = '0;
            wb_wdata_d  = '0;
        end else if (!hold_wb) begin
            if (hold_mem) begin
                // EX/MEM keeps its entry, so MEM/WB must not see it twice.
                wb_wreg_d  = 1'b0;
                wb_waddr_d = '0;
                wb_wdata_d = '0;
            end else begin
                wb_wreg_d  = mem_wreg_q;
                wb_waddr_d = mem_waddr_q;
                wb_wdata_d = mem_wdata_q;
                if (ex_kill) begin
                    mem_wreg_d  = 1'b0;
                    mem_waddr_d = '0;
                    mem_wdata_d = '0;
                end else begin
                    mem_wreg_d  = bus.ex_wreg_i;
                    mem_waddr_d = bus.ex_waddr_i;
                    mem_wdata_d = bus.ex_wdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wreg_q  <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            wb_wreg_q   <= 1'b0;
            wb_waddr_q  <= '0;
            wb_wdata_q  <= '0;
            cnt_q       <= '0;
        end else begin
            mem_wreg_q  <= mem_wreg_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_wreg_q   <= wb_wreg_d;
            wb_waddr_q  <= wb_waddr_d;
            wb_wdata_q  <= wb_wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.mem_wreg_o  = mem_wreg_q;
    assign bus.mem_waddr_o = mem_waddr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.wb_wreg_o   = wb_wreg_q;
    assign bus.wb_waddr_o  = wb_waddr_q;
    assign bus.wb_wdata_o  = wb_wdata_q;
    assign bus.wb_count_o  = cnt_q;

endmodule
